cpu_trace_tx: RTL and testbench

- On-chip trace transmitter for the CPU core; the hardware counterpart of the bench-side cycle/register dump.
- Counts clock cycles and watches the decoded opcode.
- On HLT (opcode 63), or on an external dump request, snapshots the cycle count and instruction, then streams a frame: cycle, instruction, registers r0..r31.
- Frame goes out on a valid/ready word interface to a host-side reader (UART/JTAG bridge).

---
 rtl/cpu_trace_pkg.sv | 32 +++
 rtl/cpu_trace_cycle_ctr.sv | 19 +
 rtl/cpu_trace_tx.sv | 159 +++++++++++++++
 tb/tb_cpu_trace_tx.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the CPU trace transmitter.
// Optional checksum word is enabled by defining CPU_TRACE_CHECKSUM_EN.
package cpu_trace_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CYC,
        INS,
        REGS,
        CSUM
    } state_t;

    localparam int HALT_OPCODE_DEF = 63;
    localparam int NREGS_DEF       = 32;

    localparam int WORD_CYC   = 0;
    localparam int WORD_INSTR = 1;
    localparam int WORD_REG0  = 2;

`ifdef CPU_TRACE_CHECKSUM_EN
    localparam int CSUM_WORDS = 1;
`else
    localparam int CSUM_WORDS = 0;
`endif

    function automatic int frame_len(input int nregs);
        return nregs + WORD_REG0 + CSUM_WORDS;
    endfunction

    localparam int FRAME_LEN = frame_len(NREGS_DEF);

endpackage

// File: rtl/cpu_trace_cycle_ctr.sv
// Free-running wrapping cycle counter with asynchronous active-low reset.
module cpu_trace_cycle_ctr #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_cnt <= '0;
        else      r_cnt <= r_cnt + CNT_W'(1);
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/cpu_trace_tx.sv
// Trace transmitter: snapshots cycle/instruction on HLT or dump request and streams
// cycle, instruction, r0..r(NREGS-1) (plus an XOR word when CPU_TRACE_CHECKSUM_EN).
module cpu_trace_tx
    import cpu_trace_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 32,
    parameter int NREGS       = NREGS_DEF,
    parameter int HALT_OPCODE = HALT_OPCODE_DEF,
    localparam int AW         = (NREGS > 1) ? $clog2(NREGS) : 1,
    localparam int IW         = $clog2(NREGS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr,
    input  logic [5:0]        opcode,
    input  logic              dump_req,
    output logic [AW-1:0]     rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_last,
    output logic              busy,
    output logic              halted
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt;
    logic [DATA_W-1:0] r_snap_instr;
    logic [DATA_W-1:0] r_data;
    logic [IW-1:0]     r_idx;
    logic              r_valid;
    logic              r_last;
    logic              r_busy;
    logic              r_halted;
    logic              r_halt_frame;
    logic              w_is_hlt;
    logic              w_trig;
    logic              w_hs;
    logic              w_done;
    logic              w_regs_done;
`ifdef CPU_TRACE_CHECKSUM_EN
    logic [DATA_W-1:0] r_csum;
`endif

    cpu_trace_cycle_ctr #(.CNT_W(CNT_W)) u_ctr (
        .clk (clk),
        .rst (rst),
        .cnt (w_cnt)
    );

    assign w_is_hlt    = (opcode == 6'(HALT_OPCODE));
    assign w_trig      = (r_state == IDLE) && !r_halted && (w_is_hlt || dump_req);
    assign w_hs        = r_valid && tx_ready;
    assign w_done      = w_hs && r_last;
    assign w_regs_done = (r_idx == IW'(NREGS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        rf_raddr    = '0;
        case (r_state)
            IDLE: if (w_trig) w_state_nxt = CYC;
            CYC:  if (w_hs)   w_state_nxt = INS;
            INS:  if (w_hs)   w_state_nxt = REGS;
            REGS: begin
                rf_raddr = r_idx[AW-1:0];
                if (w_done) w_state_nxt = IDLE;
`ifdef CPU_TRACE_CHECKSUM_EN
                else if (w_hs && w_regs_done) w_state_nxt = CSUM;
`endif
            end
            CSUM:    if (w_hs) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Word registers: each accepted word is replaced by the next one in frame order
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data       <= '0;
            r_snap_instr <= '0;
            r_idx        <= '0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_busy       <= 1'b0;
            r_halted     <= 1'b0;
            r_halt_frame <= 1'b0;
`ifdef CPU_TRACE_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else if (w_done) begin
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= r_halted | r_halt_frame;
        end else begin
            case (r_state)
                IDLE: if (w_trig) begin
                    r_data       <= DATA_W'(w_cnt);
                    r_snap_instr <= instr;
                    r_valid      <= 1'b1;
                    r_busy       <= 1'b1;
                    r_halt_frame <= w_is_hlt;
`ifdef CPU_TRACE_CHECKSUM_EN
                    r_csum       <= DATA_W'(w_cnt);
`endif
                end
                CYC: if (w_hs) begin
                    r_data <= r_snap_instr;
`ifdef CPU_TRACE_CHECKSUM_EN
                    r_csum <= r_csum ^ r_snap_instr;
`endif
                end
                INS: if (w_hs) begin
                    r_data <= rf_rdata;
                    r_idx  <= IW'(1);
`ifdef CPU_TRACE_CHECKSUM_EN
                    r_csum <= r_csum ^ rf_rdata;
`else
                    r_last <= (NREGS == 1);
`endif
                end
                REGS: if (w_hs) begin
                    if (!w_regs_done) begin
                        r_data <= rf_rdata;
                        r_idx  <= r_idx + IW'(1);
`ifdef CPU_TRACE_CHECKSUM_EN
                        r_csum <= r_csum ^ rf_rdata;
`else
                        r_last <= (r_idx == IW'(NREGS - 1));
`endif
                    end
`ifdef CPU_TRACE_CHECKSUM_EN
                    else begin
                        // XOR of every word already sent becomes the final word
                        r_data <= r_csum;
                        r_last <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign tx_valid = r_valid;
    assign tx_data  = r_data;
    assign tx_last  = r_last;
    assign busy     = r_busy;
    assign halted   = r_halted;

endmodule

// File: tb/tb_cpu_trace_tx.sv
// Self-checking bench for cpu_trace_tx: frames are compared against a list built
// from the frame rules (cycle, instr, r0..r31, optional XOR word).
module tb_cpu_trace_tx;

    localparam int NR = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = '0;
    logic [5:0]  opcode = '0;
    logic        dump_req = 1'b0;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] tx_data;
    logic        tx_last;
    logic        busy;
    logic        halted;

    logic [31:0] rf [NR];
    logic [31:0] tb_cyc;
    logic [31:0] cap_d [$];
    logic        cap_l [$];
    logic [31:0] exp_q [$];
    int          stall_err;
    int          tests = 0;
    int          fails = 0;

    cpu_trace_tx dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .opcode   (opcode),
        .dump_req (dump_req),
        .rf_raddr (rf_raddr),
        .rf_rdata (rf_rdata),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .busy     (busy),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    assign rf_rdata = rf[rf_raddr];

    // Number of clock edges seen since reset release
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_cyc <= '0;
        else      tb_cyc <= tb_cyc + 32'd1;
    end

    function automatic logic [5:0] non_hlt();
        return 6'($urandom_range(0, 62));
    endfunction

    task automatic build_expected(input logic [31:0] cyc, input logic [31:0] ins);
        logic [31:0] x;
        exp_q.delete();
        exp_q.push_back(cyc);
        exp_q.push_back(ins);
        for (int i = 0; i < NR; i++) exp_q.push_back(rf[i]);
`ifdef CPU_TRACE_CHECKSUM_EN
        x = '0;
        foreach (exp_q[i]) x ^= exp_q[i];
        exp_q.push_back(x);
`else
        x = '0;
`endif
    endtask

    task automatic fill_rf(input int mode);
        for (int i = 0; i < NR; i++)
            rf[i] = (mode == 0) ? 32'h100 + 32'(i) : (mode == 1) ? 32'(i) : $urandom;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; tx_ready = 1'b0; opcode = non_hlt(); dump_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_cyc(input logic [31:0] target);
        while (tb_cyc != target) @(negedge clk);
    endtask

    // Called at a negedge; trigger is sampled at the next posedge
    task automatic fire(input bit hlt, input bit dreq, input logic [31:0] ins,
                        output logic [31:0] cyc);
        opcode = hlt ? 6'd63 : non_hlt();
        dump_req = dreq;
        instr = ins;
        cyc = tb_cyc;
        @(posedge clk);
        #1;
        opcode = non_hlt();
        dump_req = 1'b0;
        instr = $urandom;
    endtask

    // mode 0: ready always, 1: 1010..., 2: random. inj: word count at which a new trigger is raised
    task automatic receive_frame(input int mode, input int inj, output bit timeout);
        bit          prev_stall;
        bit          inj_active;
        bit          r;
        logic [31:0] pd;
        logic        pl;
        cap_d.delete(); cap_l.delete();
        stall_err = 0; timeout = 1'b1; prev_stall = 1'b0; inj_active = 1'b0;
        pd = '0; pl = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (inj_active) begin opcode = non_hlt(); dump_req = 1'b0; inj_active = 1'b0; end
            if (prev_stall && (!tx_valid || tx_data !== pd || tx_last !== pl)) stall_err++;
            r = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            tx_ready = r;
            if (tx_valid && r) begin
                cap_d.push_back(tx_data);
                cap_l.push_back(tx_last);
                if (cap_d.size() == inj) begin opcode = 6'd63; dump_req = 1'b1; inj_active = 1'b1; end
                if (tx_last) begin timeout = 1'b0; break; end
            end
            prev_stall = tx_valid && !r;
            pd = tx_data; pl = tx_last;
        end
        @(negedge clk);
        opcode = non_hlt(); dump_req = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || tx_last !== 1'b0 ||
            tx_data !== 32'h0 || rf_raddr !== 5'h0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b busy=%b halted=%b last=%b data=%h raddr=%h, expected all 0",
                     tx_valid, busy, halted, tx_last, tx_data, rf_raddr);
        end
    endtask

    task automatic test_halt_frame();
        logic [31:0] cyc; bit to; int bad; int first;
        fill_rf(0);
        apply_reset();
        wait_cyc(32'd10);
        fire(1'b1, 1'b0, 32'hFC00_1234, cyc);
        build_expected(cyc, 32'hFC00_1234);
        receive_frame(0, -1, to);
        tests++;
        if (cyc !== 32'd10 || exp_q[0] !== 32'h0000_000A) begin
            fails++; $display("FAIL halt_cycle_word: got %h, expected 0000000a", exp_q[0]);
        end
        bad = 0; first = -1;
        foreach (exp_q[i])
            if (i >= cap_d.size() || cap_d[i] !== exp_q[i] || cap_l[i] !== (i == exp_q.size() - 1)) begin
                bad++; if (first < 0) first = i;
            end
        tests++;
        if (to || bad != 0 || cap_d.size() != exp_q.size()) begin
            fails++;
            $display("FAIL halt_frame: got %0d words (%0d bad, first at %0d, timeout=%0b), expected %0d words",
                     cap_d.size(), bad, first, to, exp_q.size());
        end
        tests++;
        if (halted !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL halt_flags: got halted=%b busy=%b, expected halted=1 busy=0", halted, busy);
        end
    endtask

    task automatic test_stall_dump();
        logic [31:0] cyc; bit to; int bad; int first; logic [31:0] ins;
        fill_rf(2);
        apply_reset();
        wait_cyc(32'($urandom_range(3, 30)));
        ins = $urandom;
        fire(1'b0, 1'b1, ins, cyc);
        build_expected(cyc, ins);
        receive_frame(1, -1, to);
        bad = 0; first = -1;
        foreach (exp_q[i])
            if (i >= cap_d.size() || cap_d[i] !== exp_q[i] || cap_l[i] !== (i == exp_q.size() - 1)) begin
                bad++; if (first < 0) first = i;
            end
        tests++;
        if (to || bad != 0 || cap_d.size() != exp_q.size()) begin
            fails++;
            $display("FAIL stall_frame: got %0d words (%0d bad, first at %0d, timeout=%0b), expected %0d words",
                     cap_d.size(), bad, first, to, exp_q.size());
        end
        tests++;
        if (stall_err != 0) begin
            fails++; $display("FAIL stall_stable: got %0d unstable stall cycles, expected 0", stall_err);
        end
        tests++;
        if (halted !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL dump_flags: got halted=%b busy=%b, expected halted=0 busy=0", halted, busy);
        end
    endtask

    task automatic test_both_trigger();
        logic [31:0] cyc; bit to; int extra; logic [31:0] ins;
        fill_rf(2);
        apply_reset();
        wait_cyc(32'($urandom_range(3, 30)));
        ins = $urandom;
        fire(1'b1, 1'b1, ins, cyc);
        build_expected(cyc, ins);
        receive_frame(0, -1, to);
        tests++;
        if (to || cap_d.size() != exp_q.size() || cap_d[0] !== exp_q[0] ||
            cap_d[exp_q.size()-1] !== exp_q[exp_q.size()-1]) begin
            fails++; $display("FAIL both_frame: got %0d words, expected %0d", cap_d.size(), exp_q.size());
        end
        tests++;
        if (halted !== 1'b1) begin
            fails++; $display("FAIL both_halted: got %b, expected 1", halted);
        end
        extra = 0;
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0; opcode = 6'd63;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_valid || busy) extra++;
        end
        opcode = non_hlt();
        tests++;
        if (extra != 0) begin
            fails++; $display("FAIL halted_blocks: got %0d cycles with valid/busy after halt, expected 0", extra);
        end
    endtask

    task automatic test_busy_retrigger();
        logic [31:0] cyc; bit to; int bad; int extra; logic [31:0] ins;
        fill_rf(2);
        apply_reset();
        wait_cyc(32'($urandom_range(3, 30)));
        ins = $urandom;
        fire(1'b0, 1'b1, ins, cyc);
        build_expected(cyc, ins);
        receive_frame(0, 5, to);
        bad = 0;
        foreach (exp_q[i])
            if (i >= cap_d.size() || cap_d[i] !== exp_q[i] || cap_l[i] !== (i == exp_q.size() - 1)) bad++;
        tests++;
        if (to || bad != 0 || cap_d.size() != exp_q.size()) begin
            fails++;
            $display("FAIL busy_frame: got %0d words (%0d bad), expected %0d words", cap_d.size(), bad, exp_q.size());
        end
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_valid) extra++;
        end
        tests++;
        if (extra != 0 || halted !== 1'b0) begin
            fails++; $display("FAIL busy_ignored: got %0d extra valid cycles halted=%b, expected 0 and 0", extra, halted);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] cyc; bit to; int cnt; int bad; logic [31:0] ins;
        fill_rf(2);
        apply_reset();
        wait_cyc(32'($urandom_range(3, 30)));
        fire(1'b1, 1'b0, $urandom, cyc);
        cnt = 0;
        for (int c = 0; c < 100 && cnt < 12; c++) begin
            @(negedge clk);
            tx_ready = 1'b1;
            if (tx_valid) cnt++;
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (cnt != 12 || tx_valid !== 1'b0 || busy !== 1'b0 || tx_last !== 1'b0 || halted !== 1'b0) begin
            fails++;
            $display("FAIL reset_abort: got words=%0d valid=%b busy=%b last=%b halted=%b, expected 12 0 0 0 0",
                     cnt, tx_valid, busy, tx_last, halted);
        end
        @(negedge clk);
        rst = 1'b1;
        wait_cyc(32'($urandom_range(5, 40)));
        ins = $urandom;
        fire(1'b0, 1'b1, ins, cyc);
        build_expected(cyc, ins);
        receive_frame(2, -1, to);
        bad = 0;
        foreach (exp_q[i])
            if (i >= cap_d.size() || cap_d[i] !== exp_q[i] || cap_l[i] !== (i == exp_q.size() - 1)) bad++;
        tests++;
        if (to || bad != 0 || cap_d.size() != exp_q.size() || stall_err != 0) begin
            fails++;
            $display("FAIL reset_refire: got %0d words (%0d bad, %0d unstable), expected %0d words",
                     cap_d.size(), bad, stall_err, exp_q.size());
        end
    endtask

    task automatic test_checksum();
        logic [31:0] cyc; bit to; int bad;
        fill_rf(1);
        apply_reset();
        wait_cyc(32'd3);
        fire(1'b1, 1'b0, 32'hFC00_0000, cyc);
        build_expected(cyc, 32'hFC00_0000);
        receive_frame(0, -1, to);
        bad = 0;
        foreach (exp_q[i])
            if (i >= cap_d.size() || cap_d[i] !== exp_q[i] || cap_l[i] !== (i == exp_q.size() - 1)) bad++;
        tests++;
        if (to || bad != 0 || cap_d.size() != exp_q.size()) begin
            fails++;
            $display("FAIL csum_frame: got %0d words (%0d bad), expected %0d words", cap_d.size(), bad, exp_q.size());
        end
`ifdef CPU_TRACE_CHECKSUM_EN
        tests++;
        if (cap_d.size() != 35 || cap_d[cap_d.size()-1] !== 32'hFC00_0003 || cap_l[cap_l.size()-1] !== 1'b1) begin
            fails++;
            $display("FAIL csum_word: got %0d words last=%h, expected 35 words last=fc000003",
                     cap_d.size(), (cap_d.size() > 0) ? cap_d[cap_d.size()-1] : 32'hx);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] cyc; bit to; int bad; logic [31:0] ins;
        apply_reset();
        for (int f = 0; f < 3; f++) begin
            fill_rf(2);
            repeat ($urandom_range(1, 8)) @(negedge clk);
            ins = $urandom;
            fire(1'b0, 1'b1, ins, cyc);
            build_expected(cyc, ins);
            receive_frame(2, -1, to);
            bad = 0;
            foreach (exp_q[i])
                if (i >= cap_d.size() || cap_d[i] !== exp_q[i] || cap_l[i] !== (i == exp_q.size() - 1)) bad++;
            tests++;
            if (to || bad != 0 || cap_d.size() != exp_q.size() || stall_err != 0) begin
                fails++;
                $display("FAIL random_frame%0d: got %0d words (%0d bad, %0d unstable), expected %0d words",
                         f, cap_d.size(), bad, stall_err, exp_q.size());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) rf[i] = '0;
        test_reset();
        test_halt_frame();
        test_stall_dump();
        test_both_trigger();
        test_busy_retrigger();
        test_reset_mid_frame();
        test_checksum();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
